// File: rtl/score_keeper.sv
// Runner game session sequencer: run/pause/over state, BCD survival score,
// session high score and difficulty level, all advanced on the 100 ms game tick.
module score_keeper #(
  parameter int unsigned RESTART_CODE = 17,
  parameter int unsigned START_CODE   = 16,
  parameter int unsigned LEVEL_TICKS  = 50,
  parameter int unsigned MAX_LEVEL    = 10
) (
  input  logic        clk_100ms,
  input  logic        reset,
  input  logic [4:0]  key_code,
  input  logic        pause,
  input  logic        gameover,
  output logic [1:0]  state,
  output logic [15:0] score_bcd,
  output logic [15:0] hiscore_bcd,
  output logic [3:0]  level,
  output logic        new_record
);

  localparam int unsigned TICK_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         score_q, score_d;
  logic [15:0]         hiscore_q, hiscore_d;
  logic [3:0]          level_q, level_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                new_record_q, new_record_d;
  logic                restart_c, start_c, record_c;

  // Four-digit BCD increment that sticks at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign restart_c = (key_code == 5'(RESTART_CODE));
  assign start_c   = (key_code == 5'(START_CODE));
  // Valid BCD orders the same as plain binary, so a straight compare suffices.
  assign record_c  = (score_q > hiscore_q);

  always_ff @(posedge clk_100ms) begin
    if (reset) begin
      state_q      <= IDLE;
      score_q      <= '0;
      hiscore_q    <= '0;
      level_q      <= '0;
      tick_q       <= '0;
      new_record_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      hiscore_q    <= hiscore_d;
      level_q      <= level_d;
      tick_q       <= tick_d;
      new_record_q <= new_record_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    hiscore_d    = hiscore_q;
    level_d      = level_q;
    tick_d       = tick_q;
    new_record_d = new_record_q;

    if (restart_c) begin
      state_d      = RUN;
      score_d      = '0;
      level_d      = '0;
      tick_d       = '0;
      new_record_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_c) begin
            state_d = RUN;
            score_d = '0;
            level_d = '0;
            tick_d  = '0;
          end
        end
        RUN: begin
          if (gameover) begin
            state_d      = OVER;
            new_record_d = record_c;
            if (record_c) hiscore_d = score_q;
          end else if (pause) begin
            state_d = PAUSED;
          end else begin
            score_d = bcd_inc(score_q);
            if (tick_q == TICK_W'(LEVEL_TICKS - 1)) begin
              tick_d = '0;
              if (level_q != 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end
        end
        PAUSED: begin
          if (gameover) begin
            state_d      = OVER;
            new_record_d = record_c;
            if (record_c) hiscore_d = score_q;
          end else if (!pause) begin
            state_d = RUN;
          end
        end
        OVER: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign score_bcd   = score_q;
  assign hiscore_bcd = hiscore_q;
  assign level       = level_q;
  assign new_record  = new_record_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random ticks,
// compared every tick against an integer-arithmetic model of the game rules.
module tb_score_keeper;

  localparam int RESTART = 17;
  localparam int START   = 16;
  localparam int LTICKS  = 50;
  localparam int MAXLVL  = 10;

  logic        clk_100ms;
  logic        reset;
  logic [4:0]  key_code;
  logic        pause;
  logic        gameover;
  logic [1:0]  state;
  logic [15:0] score_bcd;
  logic [15:0] hiscore_bcd;
  logic [3:0]  level;
  logic        new_record;

  int checks = 0;
  int errors = 0;

  // Model: n counts scoring ticks since the run began; score and level derive from it.
  int m_st = 0;
  int m_n  = 0;
  int m_hi = 0;
  int m_nr = 0;

  score_keeper dut (
    .clk_100ms  (clk_100ms),
    .reset      (reset),
    .key_code   (key_code),
    .pause      (pause),
    .gameover   (gameover),
    .state      (state),
    .score_bcd  (score_bcd),
    .hiscore_bcd(hiscore_bcd),
    .level      (level),
    .new_record (new_record)
  );

  initial clk_100ms = 1'b0;
  always #5 clk_100ms = ~clk_100ms;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int m_score();
    return (m_n > 9999) ? 9999 : m_n;
  endfunction

  function automatic int m_level();
    return ((m_n / LTICKS) > MAXLVL) ? MAXLVL : (m_n / LTICKS);
  endfunction

  task automatic model_over();
    m_st = 3;
    if (m_score() > m_hi) begin
      m_hi = m_score();
      m_nr = 1;
    end else begin
      m_nr = 0;
    end
  endtask

  task automatic model_step(input int k, input bit p, input bit g, input bit r);
    if (r) begin
      m_st = 0; m_n = 0; m_hi = 0; m_nr = 0;
    end else if (k == RESTART) begin
      m_st = 1; m_n = 0; m_nr = 0;
    end else begin
      case (m_st)
        0: if (k == START) begin m_st = 1; m_n = 0; end
        1: if (g) model_over(); else if (p) m_st = 2; else m_n++;
        2: if (g) model_over(); else if (!p) m_st = 1;
        default: ;
      endcase
    end
  endtask

  // One game tick: drive, clock, advance the model, compare all outputs.
  task automatic tick(input int k, input bit p, input bit g, input bit r);
    key_code = 5'(k);
    pause    = p;
    gameover = g;
    reset    = r;
    @(posedge clk_100ms);
    model_step(k, p, g, r);
    #1;
    check("state",      32'(state),       32'(m_st));
    check("score",      32'(score_bcd),   32'(to_bcd(m_score())));
    check("hiscore",    32'(hiscore_bcd), 32'(to_bcd(m_hi)));
    check("level",      32'(level),       32'(m_level()));
    check("new_record", 32'(new_record),  32'(m_nr));
  endtask

  task automatic run(input int cnt, input bit p);
    for (int i = 0; i < cnt; i++) tick(0, p, 1'b0, 1'b0);
  endtask

  initial begin
    key_code = '0;
    pause    = 1'b0;
    gameover = 1'b0;
    reset    = 1'b1;

    // Reset, then IDLE ignores pause, gameover and stray keys.
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 1, 1, 0);
    tick(5, 0, 1, 0);

    // Start and count through the 0099 -> 0100 carry.
    tick(START, 0, 0, 0);
    run(123, 0);
    check("score_0123", 32'(score_bcd), 32'h0123);

    // Level step while running, freeze while paused.
    tick(RESTART, 0, 0, 0);
    run(60, 0);
    run(20, 1);
    check("paused_state", 32'(state), 32'd2);
    run(5, 0);
    check("level_after_pause", 32'(level), 32'd1);

    // Game over at 0042 is a record; restart keeps hiscore.
    tick(RESTART, 0, 0, 0);
    run(42, 0);
    tick(0, 0, 1, 0);
    check("over_hiscore", 32'(hiscore_bcd), 32'h0042);
    check("over_record",  32'(new_record),  32'd1);
    tick(0, 0, 1, 0);
    run(3, 0);
    check("over_stays", 32'(state), 32'd3);
    tick(RESTART, 0, 0, 0);
    // Tying the hiscore is not a record; game over from PAUSED too.
    run(42, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    check("tie_no_record", 32'(new_record), 32'd0);

    // Long run: score saturates at 9999, level at MAX_LEVEL.
    tick(RESTART, 0, 0, 0);
    run(10005, 0);
    check("score_sat", 32'(score_bcd), 32'h9999);
    check("level_sat", 32'(level), 32'(MAXLVL));
    tick(0, 0, 1, 0);

    // Held restart pins score at 0; restart beats gameover; gameover beats pause.
    tick(RESTART, 0, 0, 0);
    tick(RESTART, 0, 0, 0);
    run(7, 0);
    tick(0, 1, 1, 0);
    tick(RESTART, 0, 1, 0);
    run(4, 0);
    tick(0, 0, 0, 1);
    check("reset_midrun", 32'(state), 32'd0);

    // Random ticks.
    for (int i = 0; i < 3000; i++) begin
      int sel, k;
      sel = int'($urandom_range(0, 19));
      if (sel < 12)      k = 0;
      else if (sel < 15) k = START;
      else if (sel < 16) k = RESTART;
      else               k = int'($urandom_range(0, 31));
      tick(k, ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
